// File: rtl/ftm_buffer_writer.sv
// Write side of the banked feature-map buffer: scatters a raster stream (x outer, y, 64-ch chunk inner)
// into N_BUF_X column-interleaved banks. Optional FTM_WR_OVF_CHK_EN adds a sticky address-overflow flag.
module ftm_buffer_writer #(
  parameter int unsigned N_BUF_X    = 5,
  parameter int unsigned B_BUF_ADDR = 9,
  parameter int unsigned B_SHAPE    = 32,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [B_SHAPE-1:0]             ftm_shape,
  input  logic                           s_valid,
  input  logic [DATA_WIDTH-1:0]          s_data,
  output logic                           s_ready,
  output logic [N_BUF_X-1:0]             wren,
  output logic [B_BUF_ADDR*N_BUF_X-1:0]  wraddr,
  output logic [DATA_WIDTH-1:0]          wrdata,
  output logic                           busy,
  output logic                           done
`ifdef FTM_WR_OVF_CHK_EN
  ,
  output logic                           ovf
`endif
);

  localparam int unsigned AW  = B_BUF_ADDR + 8;
  localparam int unsigned RXW = (N_BUF_X > 1) ? $clog2(N_BUF_X) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} state_t;
  state_t state, state_nxt;

  logic [5:0]         n_wrap_q;
  logic [9:0]         h_q, w_q;
  logic [5:0]         cw;
  logic [9:0]         y, x;
  logic [AW-1:0]      off, col_base, hn, addr_full;
  logic [RXW-1:0]     rx;
  logic [N_BUF_X-1:0] bank_sel;
  logic               beat, last_beat, last_off, last_rx, start_zero, write_ok;
  logic               unused_c_lsb;

  // Channel count below one 64-word chunk does not affect n_wrap
  assign unused_c_lsb = ^ftm_shape[25:20];

  assign start_zero = (ftm_shape[31:26] == '0) || (ftm_shape[19:10] == '0) || (ftm_shape[9:0] == '0);
  assign hn         = AW'(h_q) * AW'(n_wrap_q);
  assign addr_full  = col_base + off;
  assign s_ready    = (state == ST_WRITE);
  assign busy       = (state != ST_IDLE);
  assign beat       = s_valid & s_ready;
  assign last_beat  = (cw == n_wrap_q - 6'd1) && (y == h_q - 10'd1) && (x == w_q - 10'd1);
  assign last_off   = (off == hn - AW'(1));
  assign last_rx    = (rx == RXW'(N_BUF_X - 1));

`ifdef FTM_WR_OVF_CHK_EN
  logic addr_ovf;
  assign addr_ovf = (addr_full[AW-1:B_BUF_ADDR] != '0);
  assign write_ok = beat & ~addr_ovf;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_full[AW-1:B_BUF_ADDR];
  assign write_ok       = beat;
`endif

  always_comb begin
    bank_sel = '0;
    for (int unsigned i = 0; i < N_BUF_X; i++) begin
      bank_sel[i] = (rx == RXW'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = start_zero ? ST_DONE : ST_WRITE;
      ST_WRITE: if (beat && last_beat) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      n_wrap_q <= '0;
      h_q      <= '0;
      w_q      <= '0;
      cw       <= '0;
      y        <= '0;
      x        <= '0;
      off      <= '0;
      rx       <= '0;
      col_base <= '0;
      wren     <= '0;
      wraddr   <= '0;
      wrdata   <= '0;
      done     <= 1'b0;
`ifdef FTM_WR_OVF_CHK_EN
      ovf      <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      // done trails the DONE state by one cycle so it follows the last registered write
      done   <= (state == ST_DONE);
      wren   <= write_ok ? bank_sel : '0;
      wrdata <= write_ok ? s_data : '0;
      for (int unsigned i = 0; i < N_BUF_X; i++) begin
        wraddr[i*B_BUF_ADDR +: B_BUF_ADDR] <= (write_ok && bank_sel[i]) ? addr_full[B_BUF_ADDR-1:0] : '0;
      end

      if (state == ST_IDLE && start) begin
        n_wrap_q <= ftm_shape[31:26];
        h_q      <= ftm_shape[19:10];
        w_q      <= ftm_shape[9:0];
        cw       <= '0;
        y        <= '0;
        x        <= '0;
        off      <= '0;
        rx       <= '0;
        col_base <= '0;
`ifdef FTM_WR_OVF_CHK_EN
        ovf      <= 1'b0;
`endif
      end

      if (beat) begin
`ifdef FTM_WR_OVF_CHK_EN
        if (addr_ovf) ovf <= 1'b1;
`endif
        if (cw == n_wrap_q - 6'd1) begin
          cw <= '0;
          if (y == h_q - 10'd1) begin
            y <= '0;
            x <= x + 10'd1;
          end else begin
            y <= y + 10'd1;
          end
        end else begin
          cw <= cw + 6'd1;
        end
        // Column end: advance bank; past the last bank, step the base by one column height
        if (last_off) begin
          off <= '0;
          if (last_rx) begin
            rx       <= '0;
            col_base <= col_base + hn;
          end else begin
            rx <= rx + RXW'(1);
          end
        end else begin
          off <= off + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ftm_buffer_writer.sv
// Randomized self-checking bench for ftm_buffer_writer against a formula-based model of the bank layout.
module tb_ftm_buffer_writer;
  localparam int N  = 5;
  localparam int B  = 9;
  localparam int DW = 64;
`ifdef FTM_WR_OVF_CHK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic            clk = 1'b0, rstn = 1'b0, start = 1'b0, s_valid = 1'b0;
  logic [31:0]     ftm_shape = '0;
  logic [DW-1:0]   s_data = '0;
  logic            s_ready, busy, done;
  logic [N-1:0]    wren;
  logic [N*B-1:0]  wraddr;
  logic [DW-1:0]   wrdata;
`ifdef FTM_WR_OVF_CHK_EN
  logic            ovf;
`endif

  ftm_buffer_writer #(.N_BUF_X(N), .B_BUF_ADDR(B), .B_SHAPE(32), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .ftm_shape(ftm_shape), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .wren(wren), .wraddr(wraddr), .wrdata(wrdata), .busy(busy), .done(done)
`ifdef FTM_WR_OVF_CHK_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int total_n = 0, bad_n = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk_shape(input int c, input int h, input int w);
    return {12'(c), 10'(h), 10'(w)};
  endfunction

  // Layout straight from the addressing rule: bank = x % N, addr = n*(y + h*(x/N)) + cw
  function automatic int exp_bank(input int n, input int h, input int k);
    return (k / (n * h)) % N;
  endfunction
  function automatic int exp_addr(input int n, input int h, input int k);
    int cw, y, x;
    cw = k % n;
    y  = (k / n) % h;
    x  = k / (n * h);
    return n * (y + h * (x / N)) + cw;
  endfunction

  // Model state: 0 idle, 1 accepting words, 2 finishing
  int m_mode = 0, m_k, m_total, m_n, m_h, m_w, beats = 0, a, b;
  logic [N-1:0]   e_wren = '0;
  logic [N*B-1:0] e_wraddr = '0;
  logic [DW-1:0]  e_wrdata = '0;
  logic           e_done = 1'b0, e_ovf = 1'b0;

  bit done_seen;
  int wr_cnt, last_wr_cyc, done_cyc;
  logic [N-1:0] wl_wren[$];
  int           wl_addr[$];

  always @(posedge clk) begin
    int sel_addr;
    cyc++;
    if (!rstn) begin
      m_mode = 0; e_wren = '0; e_wraddr = '0; e_wrdata = '0; e_done = 1'b0; e_ovf = 1'b0;
    end else begin
      e_done = (m_mode == 2);
      e_wren = '0; e_wraddr = '0; e_wrdata = '0;
      case (m_mode)
        0: if (start) begin
             m_n = ftm_shape[31:26]; m_h = ftm_shape[19:10]; m_w = ftm_shape[9:0];
             m_total = m_n * m_h * m_w; m_k = 0; e_ovf = 1'b0;
             m_mode = (m_total == 0) ? 2 : 1;
           end
        1: if (s_valid) begin
             a = exp_addr(m_n, m_h, m_k);
             b = exp_bank(m_n, m_h, m_k);
             if (OVF_EN && a >= (1 << B)) e_ovf = 1'b1;
             else begin
               e_wren[b] = 1'b1;
               e_wraddr[b*B +: B] = a[B-1:0];
               e_wrdata = s_data;
             end
             beats++;
             if (m_k == m_total - 1) m_mode = 2;
             m_k++;
           end
        default: m_mode = 0;
      endcase
    end
    #1;
    chk("wren", 64'(wren), 64'(e_wren));
    chk("wraddr", 64'(wraddr), 64'(e_wraddr));
    chk("wrdata", wrdata, e_wrdata);
    chk("done", 64'(done), 64'(e_done));
    chk("busy", 64'(busy), 64'(m_mode != 0));
    chk("s_ready", 64'(s_ready), 64'(m_mode == 1));
`ifdef FTM_WR_OVF_CHK_EN
    chk("ovf", 64'(ovf), 64'(e_ovf));
`endif
    if (wren != '0) begin
      sel_addr = 0;
      for (int i = 0; i < N; i++) sel_addr |= int'(wraddr[i*B +: B]);
      wl_wren.push_back(wren);
      wl_addr.push_back(sel_addr);
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  task automatic run_frame(input logic [31:0] shp, input int pct, input int inj_at,
                           input logic [31:0] alt, input int rst_at);
    bit finished;
    finished = 1'b0;
    done_seen = 1'b0; wr_cnt = 0; beats = 0;
    wl_wren.delete(); wl_addr.delete();
    @(negedge clk);
    start = 1'b1; ftm_shape = shp; s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (done_seen) begin finished = 1'b1; break; end
      if (rst_at >= 0 && beats >= rst_at) begin
        rstn = 1'b0; s_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        finished = 1'b1;
        break;
      end
      if (inj_at >= 0 && beats == inj_at) begin start = 1'b1; ftm_shape = alt; end
      else start = 1'b0;
      s_valid = ($urandom_range(99) < pct);
      s_data  = {$urandom, $urandom};
      @(negedge clk);
    end
    chk("frame_timeout", 64'(finished), 64'(1));
    start = 1'b0; s_valid = 1'b0; ftm_shape = shp;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] fa;
    int n, h, w, expw;
    fa = mk_shape(128, 3, 7);

    chk("model_bank_x6", 64'(exp_bank(2, 3, 41)), 64'(1));
    chk("model_addr_x6y2cw1", 64'(exp_addr(2, 3, 41)), 64'(11));
    chk("model_addr_x5", 64'(exp_addr(2, 3, 30)), 64'(6));
    chk("model_addr_col5_big", 64'(exp_addr(8, 64, 5 * 512)), 64'(512));

    repeat (3) @(negedge clk);
    chk("reset_wren", 64'(wren), 64'(0));
    chk("reset_busy_done", 64'({busy, done, s_ready}), 64'(0));
    rstn = 1'b1;

    run_frame(fa, 100, -1, '0, -1);
    chk("a_writes", 64'(wr_cnt), 64'(42));
    if (wr_cnt == 42) begin
      chk("a_x0y0cw0", 64'({wl_wren[0], 9'(wl_addr[0])}), 64'({5'b00001, 9'd0}));
      chk("a_x1y0cw0", 64'({wl_wren[6], 9'(wl_addr[6])}), 64'({5'b00010, 9'd0}));
      chk("a_x5y0cw0", 64'({wl_wren[30], 9'(wl_addr[30])}), 64'({5'b00001, 9'd6}));
      chk("a_x6y2cw1", 64'({wl_wren[41], 9'(wl_addr[41])}), 64'({5'b00010, 9'd11}));
    end
    chk("a_done_lag", 64'(done_cyc - last_wr_cyc), 64'(1));

    run_frame(fa, 50, -1, '0, -1);
    chk("b_writes_gappy", 64'(wr_cnt), 64'(42));

    run_frame(mk_shape(32, 3, 7), 100, -1, '0, -1);
    chk("c_zero_writes", 64'(wr_cnt), 64'(0));
    chk("c_done_seen", 64'(done_seen), 64'(1));

    run_frame(fa, 70, 10, mk_shape(256, 5, 9), -1);
    chk("d_start_ignored", 64'(wr_cnt), 64'(42));

    run_frame(fa, 100, -1, '0, 20);
    chk("e_after_reset_idle", 64'({busy, done, s_ready, 5'(wren)}), 64'(0));
    run_frame(fa, 100, -1, '0, -1);
    chk("e_restart_writes", 64'(wr_cnt), 64'(42));
    if (wr_cnt > 0) chk("e_restart_first", 64'({wl_wren[0], 9'(wl_addr[0])}), 64'({5'b00001, 9'd0}));

    run_frame(mk_shape(512, 64, 6), 100, -1, '0, -1);
    chk("f_big_writes", 64'(wr_cnt), 64'(OVF_EN ? 2560 : 3072));
    chk("f_big_done", 64'(done_seen), 64'(1));
`ifdef FTM_WR_OVF_CHK_EN
    chk("f_ovf_sticky", 64'(ovf), 64'(1));
`endif

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 4);
      h = (t == 3) ? 0 : $urandom_range(1, 6);
      w = $urandom_range(1, 12);
      expw = n * h * w;
      run_frame(mk_shape(n * 64 + $urandom_range(0, 63), h, w), $urandom_range(30, 100), -1, '0, -1);
      chk("g_rand_writes", 64'(wr_cnt), 64'(expw));
    end

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule
